cmd_arbiter: RTL and testbench

CMD_ARBITER -- requirements
Module: cmd_arbiter

---
 rtl/cmd_arb_pkg.sv | 22 ++
 rtl/cmd_timer.sv | 34 +++
 rtl/cmd_arbiter.sv | 159 +++++++++++++++
 tb/tb_cmd_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_arb_pkg.sv
// cmd_arb_pkg: shared types and constants for the two-requester command arbiter.
// Optional feature macro used by the design: CMD_TIMEOUT_EN (wait-state abort timer).
package cmd_arb_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_CMD  = 3'd2,
        WAIT_RESP = 3'd3,
        DONE      = 3'd4
    } arb_state_t;

    // Response byte reported to the requester when a wait state aborts.
    localparam logic [7:0] TIMEOUT_RESP = 8'hEE;

    // A lone requester wins outright; on a tie the one not served last wins.
    function automatic logic pick_winner(input logic [1:0] req, input logic last_gnt);
        if (req == 2'b11) return ~last_gnt;
        return req[1];
    endfunction

endpackage

// File: rtl/cmd_timer.sv
// cmd_timer: wait-state cycle counter for cmd_arbiter.
// Only present when CMD_TIMEOUT_EN is defined; without it the file is empty so
// no stray counter module exists in the default build.
`ifdef CMD_TIMEOUT_EN
module cmd_timer
    import cmd_arb_pkg::*;
#(
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [19:0] cnt;

    // Clear wins over count so entry into a wait state always starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 20'd1;
        end
    end

    // Counter value k marks the (k+1)-th cycle in the wait state.
    assign expired = en && (cnt == TIMEOUT_CYCLES - 20'd1);

endmodule
`endif

// File: rtl/cmd_arbiter.sv
// cmd_arbiter: round-robin arbiter sharing one command master between two
// requesters. One transaction: latch command, strobe send, wait for the master
// to finish sending, wait for the response byte, report done to the winner.
// Optional feature macro: CMD_TIMEOUT_EN (abort a wait state after
// TIMEOUT_CYCLES cycles, report resp_out=TIMEOUT_RESP with timeout=1).
module cmd_arbiter
    import cmd_arb_pkg::*;
#(
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [15:0] cmd0,
    input  logic [15:0] cmd1,
    output logic [1:0]  done,
    output logic [7:0]  resp_out,
    output logic        timeout,
    output logic        busy,
    output logic        snd_cmd,
    output logic [15:0] cmd,
    input  logic        cmd_cmplt,
    input  logic        resp_cmplt,
    input  logic [7:0]  resp,
    output logic        clr_rdy
);

    arb_state_t state, nxt_state;
    logic       gnt;
    logic       last_gnt;
    logic       win;
    logic       tmr_exp;

    assign win = pick_winner(req, last_gnt);

`ifdef CMD_TIMEOUT_EN
    logic tmr_clr;
    logic tmr_en;
    logic to_flg;

    // Restart on entry to either wait state; count while in one.
    assign tmr_clr = (state == ISSUE) || (state == WAIT_CMD && cmd_cmplt);
    assign tmr_en  = (state == WAIT_CMD) || (state == WAIT_RESP);

    cmd_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_exp)
    );
`else
    // No timer: wait states never expire. The parameter is kept in the
    // interface so both builds share one instantiation signature.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign tmr_exp            = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt_state;
    end

    // Next-state: exit events take priority over timer expiry.
    always_comb begin
        nxt_state = state;
        case (state)
            IDLE:      if (req != 2'b00) nxt_state = ISSUE;
            ISSUE:     nxt_state = WAIT_CMD;
            WAIT_CMD: begin
                if (cmd_cmplt)    nxt_state = WAIT_RESP;
                else if (tmr_exp) nxt_state = DONE;
            end
            WAIT_RESP: begin
                if (resp_cmplt)   nxt_state = DONE;
                else if (tmr_exp) nxt_state = DONE;
            end
            DONE:      nxt_state = IDLE;
            default:   nxt_state = IDLE;
        endcase
    end

    // Outputs decoded from state. clr_rdy is held low during reset even if the
    // master still shows a byte. A byte seen in WAIT_CMD is left alone: it is
    // level-held and gets serviced once WAIT_RESP is reached.
    always_comb begin
        done    = 2'b00;
        snd_cmd = 1'b0;
        busy    = 1'b1;
        clr_rdy = 1'b0;
        timeout = 1'b0;
        case (state)
            IDLE: begin
                busy    = 1'b0;
                clr_rdy = resp_cmplt & rst_n;   // discard a stale byte
            end
            ISSUE:     snd_cmd = 1'b1;
            WAIT_RESP: clr_rdy = resp_cmplt;
            DONE: begin
                done[gnt] = 1'b1;
`ifdef CMD_TIMEOUT_EN
                timeout   = to_flg;
`endif
            end
            default: ;
        endcase
    end

    // Transaction datapath: grant/command latch on leaving IDLE, response
    // capture (or abort code) on leaving a wait state, history on DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd      <= '0;
            resp_out <= '0;
            gnt      <= 1'b0;
            last_gnt <= 1'b1;
`ifdef CMD_TIMEOUT_EN
            to_flg   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        gnt <= win;
                        cmd <= win ? cmd1 : cmd0;
`ifdef CMD_TIMEOUT_EN
                        to_flg <= 1'b0;
`endif
                    end
                end
                WAIT_CMD: begin
                    if (!cmd_cmplt && tmr_exp) begin
                        resp_out <= TIMEOUT_RESP;
`ifdef CMD_TIMEOUT_EN
                        to_flg   <= 1'b1;
`endif
                    end
                end
                WAIT_RESP: begin
                    if (resp_cmplt) begin
                        resp_out <= resp;
                    end else if (tmr_exp) begin
                        resp_out <= TIMEOUT_RESP;
`ifdef CMD_TIMEOUT_EN
                        to_flg   <= 1'b1;
`endif
                    end
                end
                DONE:    last_gnt <= gnt;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_arbiter.sv
// tb_cmd_arbiter: randomized self-checking bench for cmd_arbiter. A command
// master model answers snd_cmd; expected grants, commands, responses and
// latencies come from a request-level model of the arbitration rules.
module tb_cmd_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [15:0] cmd0 = '0, cmd1 = '0;
    logic [1:0]  done;
    logic [7:0]  resp_out;
    logic        timeout, busy, snd_cmd, clr_rdy;
    logic [15:0] cmd;
    logic        cmd_cmplt = 1'b0, resp_cmplt = 1'b0;
    logic [7:0]  resp = '0;

    int n_chk = 0;
    int n_fail = 0;
    int exp_last = 1;       // model: last requester served

    int done_total = 0;     // monitor-only counters
    int to_seen = 0;

    // results of the last run_txn
    int          r_snd, r_clr, r_bad, r_lat;
    logic [1:0]  r_done;
    logic [15:0] r_cmd;
    logic [7:0]  r_resp;
    logic        r_to;

    cmd_arbiter #(.TIMEOUT_CYCLES(20'd100)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .cmd0(cmd0), .cmd1(cmd1),
        .done(done), .resp_out(resp_out), .timeout(timeout), .busy(busy),
        .snd_cmd(snd_cmd), .cmd(cmd), .cmd_cmplt(cmd_cmplt),
        .resp_cmplt(resp_cmplt), .resp(resp), .clr_rdy(clr_rdy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done != 2'b00) done_total <= done_total + 1;
        if (timeout)       to_seen    <= to_seen + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    function automatic int model_winner(input logic [1:0] r, input int last);
        if (r == 2'b01) return 0;
        if (r == 2'b10) return 1;
        return (last == 0) ? 1 : 0;
    endfunction

    function automatic logic [1:0] onehot(input int w);
        return (w == 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; req = 2'b00; cmd_cmplt = 1'b0; resp_cmplt = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        exp_last = 1;
    endtask

    // Master model: called at posedge+1 with DUT in IDLE and req applied.
    // mode 0: resp after cmd_cmplt (+rd cycles), 1: same cycle, 2: resp early.
    task automatic run_txn(input int cd, input int rd, input int mode,
                           input logic [7:0] rb, input bit drop, input int bound);
        int phase, cnt, cyc;
        logic nxt_cc, nxt_rc;
        logic [1:0] nxt_req;
        r_snd = 0; r_clr = 0; r_bad = 0; r_lat = -1;
        r_done = 2'b00; r_cmd = '0; r_resp = '0; r_to = 1'b0;
        phase = 0; cnt = 0; cyc = 0;
        while (cyc < bound && r_done == 2'b00) begin
            @(negedge clk);
            if (snd_cmd) begin r_snd++; r_cmd = cmd; end
            else if (phase >= 1 && cmd !== r_cmd) r_bad++;
            if (clr_rdy) r_clr++;
            if (done != 2'b00) begin
                r_done = done; r_resp = resp_out; r_to = timeout; r_lat = cyc;
            end
            nxt_cc = 1'b0;
            nxt_rc = resp_cmplt & ~clr_rdy;
            nxt_req = req;
            if (phase == 0 && snd_cmd) begin
                phase = 1; cnt = 0;
                if (mode == 2) nxt_rc = 1'b1;
                if (drop) nxt_req = 2'b00;
            end
            if (phase == 1) begin
                if (cnt == cd) begin
                    nxt_cc = 1'b1; cnt = 0;
                    if (mode == 1) begin nxt_rc = 1'b1; phase = 3; end
                    else if (mode == 2) phase = 3;
                    else phase = 2;
                end else cnt++;
            end else if (phase == 2) begin
                if (cnt == rd) begin nxt_rc = 1'b1; phase = 3; end
                else cnt++;
            end
            @(posedge clk); #1;
            cmd_cmplt = nxt_cc; resp_cmplt = nxt_rc; resp = rb; req = nxt_req;
            cyc++;
        end
        req = req & ~r_done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk++; if (done !== 2'b00) begin n_fail++; $display("FAIL reset_done: got %b expected 00", done); end
        n_chk++; if ({timeout, busy, snd_cmd, clr_rdy} !== 4'b0) begin n_fail++; $display("FAIL reset_ctl: got %b expected 0000", {timeout, busy, snd_cmd, clr_rdy}); end
        n_chk++; if (cmd !== 16'h0) begin n_fail++; $display("FAIL reset_cmd: got %h expected 0000", cmd); end
        n_chk++; if (resp_out !== 8'h0) begin n_fail++; $display("FAIL reset_resp: got %h expected 00", resp_out); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        exp_last = 1;
    endtask

    task automatic test_round_robin();
        do_reset();
        cmd0 = 16'hAAAA; cmd1 = 16'h5555;
        req = 2'b11;
        for (int k = 0; k < 3; k++) begin
            int w;
            if (k == 2) req = 2'b11;
            w = model_winner(req, exp_last);
            run_txn(0, 0, 0, 8'h10 + 8'(k), 1'b0, 60);
            n_chk++; if (r_done !== onehot(w)) begin n_fail++; $display("FAIL rr_done%0d: got %b expected %b", k, r_done, onehot(w)); end
            n_chk++; if (r_cmd !== (w == 0 ? cmd0 : cmd1)) begin n_fail++; $display("FAIL rr_cmd%0d: got %h expected %h", k, r_cmd, (w == 0 ? cmd0 : cmd1)); end
            n_chk++; if (r_lat !== 4) begin n_fail++; $display("FAIL rr_lat%0d: got %0d expected 4", k, r_lat); end
            exp_last = w;
        end
        req = 2'b00;
    endtask

    task automatic test_basic();
        req = 2'b01; cmd0 = 16'h1234; cmd1 = 16'hBEEF;
        run_txn(2, 3, 0, 8'hA5, 1'b0, 60);
        n_chk++; if (r_snd !== 1) begin n_fail++; $display("FAIL basic_snd: got %0d expected 1", r_snd); end
        n_chk++; if (r_cmd !== 16'h1234) begin n_fail++; $display("FAIL basic_cmd: got %h expected 1234", r_cmd); end
        n_chk++; if (r_bad !== 0) begin n_fail++; $display("FAIL basic_cmd_stable: got %0d changes expected 0", r_bad); end
        n_chk++; if (r_clr !== 1) begin n_fail++; $display("FAIL basic_clr: got %0d expected 1", r_clr); end
        n_chk++; if (r_done !== 2'b01) begin n_fail++; $display("FAIL basic_done: got %b expected 01", r_done); end
        n_chk++; if (r_resp !== 8'hA5) begin n_fail++; $display("FAIL basic_resp: got %h expected a5", r_resp); end
        n_chk++; if (r_to !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: got %b expected 0", r_to); end
        n_chk++; if (r_lat !== 9) begin n_fail++; $display("FAIL basic_lat: got %0d expected 9", r_lat); end
        @(negedge clk);
        n_chk++; if (resp_out !== 8'hA5) begin n_fail++; $display("FAIL basic_resp_hold: got %h expected a5", resp_out); end
        @(posedge clk); #1;
        exp_last = 0;
    endtask

    task automatic test_resp_timing();
        for (int mode = 1; mode <= 2; mode++) begin
            req = 2'b10; cmd1 = 16'h0F0F + 16'(mode);
            run_txn(mode, 0, mode, 8'h3C + 8'(mode), 1'b0, 60);
            n_chk++; if (r_clr !== 1) begin n_fail++; $display("FAIL resp_mode%0d_clr: got %0d expected 1", mode, r_clr); end
            n_chk++; if (r_resp !== 8'h3C + 8'(mode)) begin n_fail++; $display("FAIL resp_mode%0d_resp: got %h expected %h", mode, r_resp, 8'h3C + 8'(mode)); end
            n_chk++; if (r_done !== 2'b10 || r_lat !== 4 + mode) begin n_fail++; $display("FAIL resp_mode%0d_done: got %b lat %0d expected 10 lat %0d", mode, r_done, r_lat, 4 + mode); end
            exp_last = 1;
        end
    endtask

    task automatic test_stale();
        int d0;
        d0 = done_total;
        resp_cmplt = 1'b1;
        @(negedge clk);
        n_chk++; if (clr_rdy !== 1'b1) begin n_fail++; $display("FAIL stale_clr: got %b expected 1", clr_rdy); end
        @(posedge clk); #1 resp_cmplt = 1'b0;
        repeat (5) begin
            @(negedge clk);
            n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stale_busy: got %b expected 0", busy); end
        end
        n_chk++; if (done_total !== d0) begin n_fail++; $display("FAIL stale_done: got %0d pulses expected 0", done_total - d0); end
        @(posedge clk); #1;
        // stale byte in the same cycle a request arrives
        req = 2'b11; cmd0 = 16'hC0DE; resp_cmplt = 1'b1;
        run_txn(0, 0, 0, 8'h77, 1'b0, 60);
        n_chk++; if (r_clr !== 2) begin n_fail++; $display("FAIL stale_req_clr: got %0d expected 2", r_clr); end
        n_chk++; if (r_done !== onehot(model_winner(2'b11, exp_last)) || r_lat !== 4) begin n_fail++; $display("FAIL stale_req_done: got %b lat %0d expected %b lat 4", r_done, r_lat, onehot(model_winner(2'b11, exp_last))); end
        exp_last = model_winner(2'b11, exp_last);
        req = 2'b00;
    endtask

    task automatic test_timeout();
        req = 2'b01; cmd0 = 16'h7777;
        run_txn(1000, 0, 0, 8'h55, 1'b0, 150);
`ifdef CMD_TIMEOUT_EN
        n_chk++; if (r_done !== 2'b01 || r_to !== 1'b1) begin n_fail++; $display("FAIL timeout_done: got done %b to %b expected 01 1", r_done, r_to); end
        n_chk++; if (r_resp !== 8'hEE) begin n_fail++; $display("FAIL timeout_resp: got %h expected ee", r_resp); end
        n_chk++; if (r_lat !== 102) begin n_fail++; $display("FAIL timeout_lat: got %0d expected 102", r_lat); end
        exp_last = 0;
`else
        n_chk++; if (r_done !== 2'b00) begin n_fail++; $display("FAIL notimeout_done: got %b expected 00", r_done); end
        n_chk++; if (busy !== 1'b1 || to_seen !== 0) begin n_fail++; $display("FAIL notimeout_wait: got busy %b to %0d expected 1 0", busy, to_seen); end
        do_reset();
`endif
        req = 2'b00;
    endtask

    task automatic test_reset_mid();
        int d0;
        req = 2'b10; cmd1 = 16'h4242;
        @(posedge clk); #1;
        @(posedge clk); #1 cmd_cmplt = 1'b1;
        @(posedge clk); #1 cmd_cmplt = 1'b0;
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b expected 1", busy); end
        rst_n = 1'b0; req = 2'b00; resp_cmplt = 1'b1;
        #1;
        n_chk++; if ({done, timeout, busy, snd_cmd, clr_rdy} !== 6'b0) begin n_fail++; $display("FAIL mid_outputs: got %b expected 000000", {done, timeout, busy, snd_cmd, clr_rdy}); end
        n_chk++; if (cmd !== 16'h0 || resp_out !== 8'h0) begin n_fail++; $display("FAIL mid_regs: got %h %h expected 0000 00", cmd, resp_out); end
        @(posedge clk); #1 resp_cmplt = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        d0 = done_total;
        repeat (10) @(posedge clk);
        #1;
        n_chk++; if (done_total !== d0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_after: got %0d pulses busy %b expected 0 0", done_total - d0, busy); end
        exp_last = 1;
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            logic [1:0] r;
            logic [7:0] rb;
            int w, cd, rd, md, el;
            bit dr;
            r = 2'($urandom_range(1, 3));
            cmd0 = 16'($urandom); cmd1 = 16'($urandom);
            cd = $urandom_range(0, 4); rd = $urandom_range(0, 4); md = $urandom_range(0, 2);
            dr = ($urandom_range(0, 3) == 0);
            rb = 8'($urandom);
            w = model_winner(r, exp_last);
            el = (md == 0) ? 4 + cd + rd : 4 + cd;
            req = r;
            run_txn(cd, rd, md, rb, dr, 60);
            n_chk++; if (r_done !== onehot(w)) begin n_fail++; $display("FAIL rand%0d_done: got %b expected %b", t, r_done, onehot(w)); end
            n_chk++; if (r_cmd !== (w == 0 ? cmd0 : cmd1) || r_snd !== 1 || r_bad !== 0) begin n_fail++; $display("FAIL rand%0d_cmd: got %h x%0d chg %0d expected %h x1 chg 0", t, r_cmd, r_snd, r_bad, (w == 0 ? cmd0 : cmd1)); end
            n_chk++; if (r_resp !== rb || r_clr !== 1) begin n_fail++; $display("FAIL rand%0d_resp: got %h clr %0d expected %h clr 1", t, r_resp, r_clr, rb); end
            n_chk++; if (r_lat !== el) begin n_fail++; $display("FAIL rand%0d_lat: got %0d expected %0d", t, r_lat, el); end
            if (r_done == 2'b00) do_reset();
            else exp_last = w;
        end
        req = 2'b00;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_basic();
        test_resp_timing();
        test_stale();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
